// File: rtl/any1_pkg.sv
// Shared types for the any1 core: operand/instruction types, the ALU record
// posted by issue logic, and the ALU queue entry (record minus write strobe).
package any1_pkg;

  typedef logic [63:0] Value;
  typedef logic [31:0] Instruction;

  localparam int ALUQ_DEPTH = 8;

  typedef struct packed {
    logic       wr;
    logic [5:0] rid;
    Instruction ir;
    Value       a;
    Value       b;
    Value       c;
    Value       d;
    Value       imm;
  } sALUrec;

  // 358-bit stored payload: everything in sALUrec except the strobe.
  typedef struct packed {
    logic [5:0] rid;
    Instruction ir;
    Value       a;
    Value       b;
    Value       c;
    Value       d;
    Value       imm;
  } sALUqEntry;

endpackage

// File: rtl/any1_alu_queue_ram.sv
// ALU queue storage: DEPTH x sALUqEntry, one synchronous write port and one
// asynchronous read port.
module any1_alu_queue_ram
  import any1_pkg::*;
#(
  parameter int DEPTH = ALUQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  sALUqEntry     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output sALUqEntry     rdata_o
);

  sALUqEntry mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers decide what is valid,
  // and leaving the array out of reset lets it map onto plain RAM/LUT cells.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/any1_alu_queue.sv
// In-order ALU operation queue between issue and the integer ALU, with flush
// and occupancy flags. Optional empty-queue bypass: define ANY1_ALUQ_BYPASS_EN.
module any1_alu_queue
  import any1_pkg::*;
#(
  parameter int DEPTH        = ALUQ_DEPTH,
  parameter int AFULL_MARGIN = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int PW          = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  sALUrec        rec_i,
  output logic          full_o,
  output logic          almost_full_o,
  output logic [PW-1:0] count_o,
  output logic          ovf_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [5:0]    rid_o,
  output Instruction    ir_o,
  output Value          a_o,
  output Value          b_o,
  output Value          c_o,
  output Value          d_o,
  output Value          imm_o
);

  localparam int AFULL_INT = (DEPTH > AFULL_MARGIN) ? DEPTH - AFULL_MARGIN : 0;
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(AFULL_INT);
  localparam logic [PW-1:0] FULL_LEVEL  = PW'(DEPTH);

  logic [PW-1:0] rd_ptr, wr_ptr, count_next;
  logic          empty, wr_accept, pop, byp_valid, byp_take;
  sALUqEntry     wr_entry, head, out_entry;

  assign wr_entry = '{rid: rec_i.rid, ir: rec_i.ir, a: rec_i.a, b: rec_i.b,
                      c: rec_i.c, d: rec_i.d, imm: rec_i.imm};

  assign empty = (rd_ptr == wr_ptr);

`ifdef ANY1_ALUQ_BYPASS_EN
  assign byp_valid = empty && rec_i.wr && !flush_i;
  assign byp_take  = byp_valid && ready_i;
`else
  assign byp_valid = 1'b0;
  assign byp_take  = 1'b0;
`endif

  // A bypassed record goes straight to the ALU and never occupies a slot.
  assign wr_accept  = rec_i.wr && !full_o && !flush_i && !byp_take;
  assign pop        = !empty && ready_i && !flush_i;
  assign count_next = count_o + PW'(wr_accept) - PW'(pop);

  any1_alu_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr[AW-1:0]),
    .rdata_o (head)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_o       <= '0;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
      ovf_o         <= 1'b0;
    end else if (flush_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_o       <= '0;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      count_o       <= count_next;
      full_o        <= (count_next == FULL_LEVEL);
      almost_full_o <= (count_next >= AFULL_LEVEL);
      // A full queue drops the write even if the head pops this cycle.
      ovf_o         <= rec_i.wr && full_o;
    end
  end

  assign valid_o   = !empty || byp_valid;
  assign out_entry = byp_valid ? wr_entry : head;

  assign rid_o = out_entry.rid;
  assign ir_o  = out_entry.ir;
  assign a_o   = out_entry.a;
  assign b_o   = out_entry.b;
  assign c_o   = out_entry.c;
  assign d_o   = out_entry.d;
  assign imm_o = out_entry.imm;

endmodule

// File: tb/tb_any1_alu_queue.sv
// Directed self-checking bench for any1_alu_queue: reset, single write, fill
// and overflow, pop during full, wrapped streaming, flush, async reset, bypass.
module tb_any1_alu_queue;
  import any1_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush = 1'b0;
  logic          ready = 1'b0;
  sALUrec        rec;
  logic          full, afull, ovf, valid;
  logic [CW-1:0] count;
  logic [5:0]    rid;
  Instruction    ir;
  Value          a, b, c, d, imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  any1_alu_queue dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush),
    .rec_i         (rec),
    .full_o        (full),
    .almost_full_o (afull),
    .count_o       (count),
    .ovf_o         (ovf),
    .valid_o       (valid),
    .ready_i       (ready),
    .rid_o         (rid),
    .ir_o          (ir),
    .a_o           (a),
    .b_o           (b),
    .c_o           (c),
    .d_o           (d),
    .imm_o         (imm)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic Value imm_of(input logic [5:0] r);
    return 64'h1_0000 + 64'(r);
  endfunction

  function automatic Value d_of(input logic [5:0] r);
    return 64'hD000_0000 + 64'(r);
  endfunction

  task automatic load(input logic [5:0] r);
    rec.rid = r;
    rec.ir  = 32'h0000_0013 + 32'(r);
    rec.a   = 64'hA000 + 64'(r);
    rec.b   = 64'hB000 + 64'(r);
    rec.c   = 64'hC000 + 64'(r);
    rec.d   = d_of(r);
    rec.imm = imm_of(r);
  endtask

  // Apply inputs for the next rising edge, then land on the following negedge.
  task automatic cyc(input logic wr, input logic rdy, input logic fl);
    rec.wr = wr;
    ready  = rdy;
    flush  = fl;
    @(negedge clk);
  endtask

  initial begin
    int sent, got, n;
    logic rdy, w;
    rec = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    check("rst_valid", 64'(valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full",  64'(full),  64'd0);
    check("rst_afull", 64'(afull), 64'd0);
    check("rst_ovf",   64'(ovf),   64'd0);

    // Single write, then pop.
    load(6'h05);
    rec.a = 64'h1;
    cyc(1'b1, 1'b0, 1'b0);
    check("w1_valid", 64'(valid), 64'd1);
    check("w1_rid",   64'(rid),   64'd5);
    check("w1_a",     a,          64'h1);
    check("w1_ir",    64'(ir),    64'h18);
    check("w1_count", 64'(count), 64'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("p1_valid", 64'(valid), 64'd0);
    check("p1_count", 64'(count), 64'd0);

    // Fill to full, then overflow with rid 8.
    for (int i = 0; i < 8; i++) begin
      load(6'(i));
      cyc(1'b1, 1'b0, 1'b0);
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_afull", 64'(afull), 64'((i + 1) >= 6));
      check("fill_full",  64'(full),  64'((i + 1) == 8));
      check("fill_ovf",   64'(ovf),   64'd0);
    end
    load(6'd8);
    cyc(1'b1, 1'b0, 1'b0);
    check("ovf_pulse", 64'(ovf),   64'd1);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_head",  64'(rid),   64'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovf_clear", 64'(ovf),  64'd0);
    check("ovf_full",  64'(full), 64'd1);

    // Pop and write together while full: write dropped, head advances.
    load(6'd9);
    cyc(1'b1, 1'b1, 1'b0);
    check("fpop_ovf",   64'(ovf),   64'd1);
    check("fpop_count", 64'(count), 64'd7);
    check("fpop_rid",   64'(rid),   64'd1);
    check("fpop_full",  64'(full),  64'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("fpop_ovf_clr", 64'(ovf), 64'd0);
    for (int k = 1; k < 8; k++) begin
      check("drain_rid", 64'(rid), 64'(k));
      check("drain_imm", imm, imm_of(6'(k)));
      cyc(1'b0, 1'b1, 1'b0);
    end
    check("drain_valid", 64'(valid), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // Stream 20 records with ready toggling: crosses the pointer wrap twice.
    sent = 0;
    got  = 0;
    n    = 0;
    while (got < 20 && n < 200) begin
      rdy = (n % 2) == 0;
      w   = (sent < 20) && !full;
      if (w) load(6'(10 + sent));
      rec.wr = w;
      ready  = rdy;
      #1;
      if (valid && rdy) begin
        check("stream_rid", 64'(rid), 64'(10 + got));
        check("stream_d",   d,        d_of(6'(10 + got)));
        got++;
      end
      @(negedge clk);
      if (w) sent++;
      n++;
    end
    check("stream_done", 64'(got), 64'd20);
    cyc(1'b0, 1'b0, 1'b0);
    check("stream_empty", 64'(valid), 64'd0);

    // Flush with a concurrent write.
    for (int i = 0; i < 3; i++) begin
      load(6'(40 + i));
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("fl_pre_count", 64'(count), 64'd3);
    load(6'd43);
    cyc(1'b1, 1'b0, 1'b1);
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(valid), 64'd0);
    check("fl_ovf",   64'(ovf),   64'd0);
    load(6'd9);
    cyc(1'b1, 1'b0, 1'b0);
    check("fl_next_valid", 64'(valid), 64'd1);
    check("fl_next_rid",   64'(rid),   64'd9);
    check("fl_next_count", 64'(count), 64'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("fl_drain", 64'(valid), 64'd0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 4; i++) begin
      load(6'(50 + i));
      cyc(1'b1, 1'b0, 1'b0);
    end
    rec.wr = 1'b0;
    check("ar_pre_count", 64'(count), 64'd4);
    #2 rst_ni = 1'b0;
    #1;
    check("ar_valid", 64'(valid), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_full",  64'(full),  64'd0);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("ar_post_valid", 64'(valid), 64'd0);
    check("ar_post_count", 64'(count), 64'd0);

`ifdef ANY1_ALUQ_BYPASS_EN
    load(6'd3);
    rec.wr = 1'b1;
    ready  = 1'b1;
    #1;
    check("byp_valid", 64'(valid), 64'd1);
    check("byp_rid",   64'(rid),   64'd3);
    @(negedge clk);
    rec.wr = 1'b0;
    ready  = 1'b0;
    #1;
    check("byp_count", 64'(count), 64'd0);
    check("byp_empty", 64'(valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
